// File: rtl/irq_controller_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : irq_controller_pkg                                            |
// | Purpose  : Shared constants and types for the pCPU interrupt controller: |
// |            register word addresses, id width and FSM state encoding.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package irq_controller_pkg;

  // Register word addresses on the peripheral bus
  localparam logic [2:0] c_ADDR_PENDING  = 3'd0;
  localparam logic [2:0] c_ADDR_ENABLE   = 3'd1;
  localparam logic [2:0] c_ADDR_CLAIM    = 3'd2;
  localparam logic [2:0] c_ADDR_RAW      = 3'd3;
  localparam logic [2:0] c_ADDR_PRIO_INV = 3'd4;

  // Source ids are 4 bits wide (up to 16 sources)
  localparam int c_IDX_W = 4;

  // Request FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

endpackage : irq_controller_pkg
`default_nettype wire

// File: rtl/irq_controller_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : irq_controller_if                                             |
// | Purpose  : Register bus between the CPU and the interrupt controller.    |
// | Signals  : a   - register word address                                   |
// |            d   - write data                                              |
// |            we  - write strobe, one cycle per write                       |
// |            spo - combinational read data for address a                   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface irq_controller_if;
  logic [2:0]  a;
  logic [31:0] d;
  logic        we;
  logic [31:0] spo;

  modport master (output a, output d, output we, input spo);
  modport slave  (input a, input d, input we, output spo);
endinterface : irq_controller_if
`default_nettype wire

// File: rtl/irq_prio_enc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : irq_prio_enc                                                  |
// | Purpose  : Priority encoder picking one active request.                  |
// | Ports    : i_req   - request vector (N_SRC bits)                         |
// |            i_dir   - 0: lowest index wins, 1: highest index wins         |
// |            o_valid - any request active                                  |
// |            o_idx   - winning index                                       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module irq_prio_enc
  import irq_controller_pkg::*;
#(
  parameter int N_SRC = 8
) (
  input  logic [N_SRC-1:0]   i_req,
  input  logic               i_dir,
  output logic               o_valid,
  output logic [c_IDX_W-1:0] o_idx
);

  // The last matching index in scan order wins, so the scan direction is
  // the opposite of the priority direction.
  always_comb begin
    o_valid = |i_req;
    o_idx   = '0;
    if (i_dir) begin
      for (int i = 0; i < N_SRC; i++) begin
        if (i_req[i]) o_idx = c_IDX_W'(i);
      end
    end else begin
      for (int i = N_SRC - 1; i >= 0; i--) begin
        if (i_req[i]) o_idx = c_IDX_W'(i);
      end
    end
  end

endmodule : irq_prio_enc
`default_nettype wire

// File: rtl/irq_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : irq_controller                                                |
// | Purpose  : N_SRC-source interrupt controller with per-source edge/level  |
// |            detection, pending/enable registers, selectable priority      |
// |            direction and a single-request handshake to the CPU.          |
// | Ports    : clk, rst_n  - clock, asynchronous active-low reset            |
// |            i_src       - raw interrupt sources                           |
// |            bus         - register bus (a, d, we, spo)                    |
// |            interrupt   - request to CPU                                  |
// |            int_istimer - latched request is the timer source             |
// |            int_reply   - one-cycle CPU acknowledge                       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int               N_SRC     = 8,
  parameter int               TIMER_SRC = 0,
  parameter logic [N_SRC-1:0] EDGE_MASK = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] i_src,
  irq_controller_if.slave  bus,
  output logic             interrupt,
  output logic             int_istimer,
  input  logic             int_reply
);

  localparam logic [c_IDX_W-1:0] c_TIMER_ID = c_IDX_W'(TIMER_SRC);

  logic [N_SRC-1:0]   r_pending;
  logic [N_SRC-1:0]   r_enable;
  logic               r_prio_inv;
  logic [N_SRC-1:0]   r_prev;
  logic               r_armed;
  logic [c_IDX_W-1:0] r_id;
  state_e             r_state;

  state_e             w_state_nxt;
  logic               w_latch;
  logic               w_reply_ack;
  logic [N_SRC-1:0]   w_set;
  logic [N_SRC-1:0]   w_clr;
  logic               w_arb_valid;
  logic [c_IDX_W-1:0] w_arb_idx;
  logic [31:0]        w_rdata;
  logic               w_wr_pending;
  logic               w_wr_enable;
  logic               w_wr_prio;
  logic               w_unused_d;

  assign w_wr_pending = bus.we && (bus.a == c_ADDR_PENDING);
  assign w_wr_enable  = bus.we && (bus.a == c_ADDR_ENABLE);
  assign w_wr_prio    = bus.we && (bus.a == c_ADDR_PRIO_INV);
  assign w_unused_d   = ^bus.d[31:N_SRC];

  // Edge detection is suppressed on the first clock after reset so that
  // r_prev can capture sources that are already high without firing.
  // Level sources set every cycle they are high, which also makes any
  // clear of a still-active level source ineffective (set wins).
  assign w_set = (i_src & ~EDGE_MASK)
               | (i_src & ~r_prev & EDGE_MASK & {N_SRC{r_armed}});

  // Clear mask: software write-1-to-clear plus the acknowledged id
  always_comb begin
    w_clr = '0;
    if (w_wr_pending) w_clr = bus.d[N_SRC-1:0];
    for (int i = 0; i < N_SRC; i++) begin
      if (w_reply_ack && (r_id == c_IDX_W'(i))) w_clr[i] = 1'b1;
    end
  end

  irq_prio_enc #(
    .N_SRC (N_SRC)
  ) u_prio_enc (
    .i_req   (r_pending & r_enable),
    .i_dir   (r_prio_inv),
    .o_valid (w_arb_valid),
    .o_idx   (w_arb_idx)
  );

  // Source tracking and software-visible registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending  <= '0;
      r_enable   <= '0;
      r_prio_inv <= 1'b0;
      r_prev     <= '0;
      r_armed    <= 1'b0;
    end else begin
      r_prev    <= i_src;
      r_armed   <= 1'b1;
      r_pending <= (r_pending & ~w_clr) | w_set;
      if (w_wr_enable) r_enable   <= bus.d[N_SRC-1:0];
      if (w_wr_prio)   r_prio_inv <= bus.d[0];
    end
  end

  // FSM state and latched id
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_id    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) r_id <= w_arb_idx;
    end
  end

  // Once in REQ the id stays frozen; only the reply moves the FSM on, so
  // software clearing or disabling the id cannot withdraw the request.
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_reply_ack = 1'b0;
    interrupt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_arb_valid) begin
          w_latch     = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        interrupt = 1'b1;
        if (int_reply) begin
          w_reply_ack = 1'b1;
          w_state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    int_istimer = interrupt && (r_id == c_TIMER_ID);
  end

  // Combinational read mux
  always_comb begin
    w_rdata = '0;
    case (bus.a)
      c_ADDR_PENDING:  w_rdata = 32'(r_pending);
      c_ADDR_ENABLE:   w_rdata = 32'(r_enable);
      c_ADDR_CLAIM:    w_rdata = {interrupt, {(31 - c_IDX_W){1'b0}}, r_id};
      c_ADDR_RAW:      w_rdata = 32'(i_src);
      c_ADDR_PRIO_INV: w_rdata = {31'b0, r_prio_inv};
      default:         w_rdata = '0;
    endcase
  end

  assign bus.spo = w_rdata;

endmodule : irq_controller
`default_nettype wire

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 SHALL have parameter N_SRC, default 8, meaning number of interrupt sources (legal range 2..16).
REQ-002 SHALL have parameter TIMER_SRC, default 0, meaning the source index reported as the timer interrupt.
REQ-003 SHALL have parameter EDGE_MASK, default all ones (N_SRC bits), meaning per source: 1 = rising-edge triggered, 0 = level triggered.
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port i_src, input, N_SRC, raw interrupt sources, synchronous to clk.
REQ-007 SHALL have port a, input, 3, register word address.
REQ-008 SHALL have port d, input, 32, write data.
REQ-009 SHALL have port we, input, 1, write strobe, one cycle per write.
REQ-010 SHALL have port spo, output, 32, combinational read data for address a.
REQ-011 SHALL have port interrupt, output, 1, request to CPU.
REQ-012 SHALL have port int_istimer, output, 1, high when the latched request is TIMER_SRC.
REQ-013 SHALL have port int_reply, input, 1, one-cycle CPU acknowledge.

Function
REQ-014 SHALL provide registers:
- 0 PENDING: read; write-1-to-clear.
- 1 ENABLE: read/write.
- 2 CLAIM: read-only; bit 31 = valid, bits 3:0 = latched id.
- 3 RAW: read-only i_src.
- 4 PRIO_INV: read/write; bit0 = 1 selects highest index wins.
- Other addresses: read 0, writes ignored.
REQ-015 Edge sources SHALL set pending one cycle after a 0->1 transition of i_src, detected against a registered previous sample.
REQ-016 Level sources SHALL set pending each cycle i_src is high; clears SHALL only take effect when i_src is low.
REQ-017 When a set and a clear hit the same pending bit in one cycle, set SHALL win.
REQ-018 Pending SHALL latch regardless of ENABLE; only arbitration is masked by ENABLE.
REQ-019 Arbitration SHALL select the lowest index among PENDING&ENABLE, or the highest index if PRIO_INV bit0 = 1.
REQ-020 FSM states SHALL be IDLE, REQ and GAP.
REQ-021 In IDLE, when any PENDING&ENABLE bit is set, the FSM SHALL:
- latch the selected id;
- go to REQ;
- assert interrupt and int_istimer = (id==TIMER_SRC) in the next cycle.
REQ-022 In REQ, interrupt SHALL stay high and the id SHALL stay frozen even if a higher-priority source arrives or the id is disabled.
REQ-023 In REQ, when int_reply = 1, the FSM SHALL clear pending[id] (subject to REQ-016/017) and go to GAP.
REQ-024 GAP SHALL last exactly one cycle with interrupt low, then return to IDLE; the minimum request-to-request spacing is 2 cycles after the reply.
REQ-025 int_reply outside REQ SHALL be ignored.
REQ-026 A write to PENDING clearing the latched id during REQ SHALL not deassert interrupt; the reply still completes normally.

Reset
REQ-027 While rst_n = 0, the block SHALL asynchronously force:
- PENDING, ENABLE, PRIO_INV, latched id and edge history = 0;
- FSM = IDLE;
- interrupt = 0 and int_istimer = 0.
REQ-028 Edge history SHALL load i_src on the first clock after reset release, so sources already high do not trigger.
REQ-029 Reset asserted mid-REQ SHALL drop interrupt immediately and lose the request.

Structure
REQ-030 Register address constants and FSM state encodings SHALL reside in the shared package/header used by the pCPU peripherals.
REQ-031 A sub-module irq_prio_enc (parametrised N_SRC, direction input, outputs valid+index) SHALL implement arbitration.

Verification
REQ-032 ENABLE=0x03; pulse i_src[1] → then 1 cycle later PENDING=0x02, and interrupt=1 with CLAIM=0x80000001 within 2 cycles.
REQ-033 Pulse i_src[0] and i_src[1] together (TIMER_SRC=0), PRIO_INV=0 → id 0, int_istimer=1. Reply → interrupt low 1 cycle (GAP) → id 1 raised, int_istimer=0.
REQ-034 Level source 2 (EDGE_MASK bit2=0) held high, reply given → PENDING bit2 stays 1 and re-interrupts after GAP. Drop source, write PENDING=0x04 → bit2 clears.
REQ-035 Edge on source 3 in the same cycle as a write of PENDING=0x08 → bit3 remains set.
REQ-036 During REQ for id 4, pulse rst_n low → interrupt and all registers read 0 asynchronously. Source 4 held high across release → no new pending.
